// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package ifetch_pkg;

  localparam int unsigned INST_BYTES     = 4;
  localparam int unsigned INST_WIDTH     = 32;
  localparam int unsigned WAIT_CNT_WIDTH = 4;
  localparam int unsigned COUNT_WIDTH    = 16;

  typedef logic [INST_WIDTH-1:0] inst_word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_VALID = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_wait_cnt.sv
// Memory wait-state down-counter: load wins over decrement, holds at zero.
module fetch_wait_cnt
  import ifetch_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [WAIT_CNT_WIDTH-1:0] load_val,
  input  logic                      dec,
  output logic                      zero_c
);

  logic [WAIT_CNT_WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - WAIT_CNT_WIDTH'(1);
    end
  end

  assign zero_c = (count_q == '0);

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, waits out memory latency, and
// hands the fetched word to the control unit under a valid/ready handshake.
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 24,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned           WAIT_STATES = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  inst_word_t             mem_rdata,
  input  logic                   fetch_req,
  output inst_word_t             ir,
  output logic                   ir_valid,
  input  logic                   ir_ready,
  output logic [ADDR_WIDTH-1:0]  pc_out,
  input  logic                   redirect_en,
  input  logic [ADDR_WIDTH-1:0]  redirect_addr,
  output logic                   align_err,
  output logic [COUNT_WIDTH-1:0] fetch_count
);

  // The counter is loaded with WAIT_STATES-1 on entering WAIT; its zero cycle is the capture cycle.
  localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LOAD =
    (WAIT_STATES == 0) ? WAIT_CNT_WIDTH'(0) : WAIT_CNT_WIDTH'(WAIT_STATES - 1);

  fetch_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]  pc_out_q, pc_out_d;
  inst_word_t             ir_q, ir_d;
  logic                   valid_q, valid_d;
  logic                   align_q, align_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   cnt_load;
  logic                   cnt_dec;
  logic                   cnt_zero_c;

  fetch_wait_cnt u_wait_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (WAIT_LOAD),
    .dec      (cnt_dec),
    .zero_c   (cnt_zero_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      pc_out_q <= RESET_PC;
      ir_q     <= '0;
      valid_q  <= 1'b0;
      align_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      ir_q     <= ir_d;
      valid_q  <= valid_d;
      align_q  <= align_d;
      count_q  <= count_d;
    end
  end

  // Redirect overrides every state, so it is resolved ahead of the state case.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    ir_d     = ir_q;
    align_d  = align_q;
    count_d  = count_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;

    if (redirect_en) begin
      state_d = ST_IDLE;
      pc_d    = {redirect_addr[ADDR_WIDTH-1:2], 2'b00};
      if (redirect_addr[1:0] != 2'b00) begin
        align_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (fetch_req) begin
            if (WAIT_STATES == 0) begin
              ir_d     = mem_rdata;
              pc_out_d = pc_q;
              state_d  = ST_VALID;
            end else begin
              cnt_load = 1'b1;
              state_d  = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_zero_c) begin
            ir_d     = mem_rdata;
            pc_out_d = pc_q;
            state_d  = ST_VALID;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        ST_VALID: begin
          if (ir_ready) begin
            pc_d    = pc_q + ADDR_WIDTH'(INST_BYTES);
            state_d = ST_IDLE;
            if (count_q != '1) begin
              count_d = count_q + COUNT_WIDTH'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    valid_d = (state_d == ST_VALID);
  end

  assign mem_addr    = pc_q;
  assign pc_out      = pc_out_q;
  assign ir          = ir_q;
  assign ir_valid    = valid_q;
  assign align_err   = align_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: two instances (0 and 3 wait states, the second at a
// wrapping reset PC) checked every cycle against a timestamp-based model.
module tb_ifetch_ctrl;

  localparam int unsigned WS [2]  = '{0, 3};
  localparam logic [23:0] RPC [2] = '{24'h000000, 24'hFFFFFC};

  typedef struct {
    logic [23:0] pc;
    logic [23:0] pc_out;
    logic [31:0] ir;
    bit          valid;
    bit          pending;
    bit          align;
    logic [15:0] count;
    int unsigned due;
  } model_t;

  logic        clk;
  logic        rst_n;
  logic        fetch_req;
  logic        ir_ready;
  logic        redirect_en;
  logic [23:0] redirect_addr;

  logic [23:0] mem_addr    [2];
  logic [31:0] mem_rdata   [2];
  logic [31:0] ir          [2];
  logic        ir_valid    [2];
  logic [23:0] pc_out      [2];
  logic        align_err   [2];
  logic [15:0] fetch_count [2];

  model_t      m [2];
  int unsigned edge_n;
  int unsigned n_checks;
  int unsigned n_pass;

  function automatic logic [31:0] mem_word(logic [23:0] a);
    case (a)
      24'h000000: return 32'hF4113005;
      24'h000004: return 32'hF4131007;
      default:    return {8'h3C, a} ^ 32'h00A5_5A00;
    endcase
  endfunction

  assign mem_rdata[0] = mem_word(mem_addr[0]);
  assign mem_rdata[1] = mem_word(mem_addr[1]);

  ifetch_ctrl #(.ADDR_WIDTH(24), .RESET_PC(24'h000000), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr[0]), .mem_rdata(mem_rdata[0]),
    .fetch_req(fetch_req), .ir(ir[0]), .ir_valid(ir_valid[0]), .ir_ready(ir_ready),
    .pc_out(pc_out[0]), .redirect_en(redirect_en), .redirect_addr(redirect_addr),
    .align_err(align_err[0]), .fetch_count(fetch_count[0])
  );

  ifetch_ctrl #(.ADDR_WIDTH(24), .RESET_PC(24'hFFFFFC), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr[1]), .mem_rdata(mem_rdata[1]),
    .fetch_req(fetch_req), .ir(ir[1]), .ir_valid(ir_valid[1]), .ir_ready(ir_ready),
    .pc_out(pc_out[1]), .redirect_en(redirect_en), .redirect_addr(redirect_addr),
    .align_err(align_err[1]), .fetch_count(fetch_count[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic model_t model_reset(int k);
    model_t s;
    s.pc = RPC[k]; s.pc_out = RPC[k]; s.ir = '0;
    s.valid = 1'b0; s.pending = 1'b0; s.align = 1'b0;
    s.count = '0; s.due = 0;
    return s;
  endfunction

  function automatic model_t deliver(model_t s);
    s.ir = mem_word(s.pc); s.pc_out = s.pc; s.valid = 1'b1; s.pending = 1'b0;
    return s;
  endfunction

  // A fetch accepted at edge n delivers at edge n+ws; the word is then valid until consumed.
  function automatic model_t model_step(model_t s, int unsigned ws, int unsigned n,
                                        bit req, bit rdy, bit redir, logic [23:0] ra);
    if (redir) begin
      s.pc = {ra[23:2], 2'b00}; s.pending = 1'b0; s.valid = 1'b0;
      if (ra[1:0] != 2'b00) s.align = 1'b1;
    end else if (s.valid) begin
      if (rdy) begin
        s.pc = s.pc + 24'd4; s.valid = 1'b0;
        if (s.count != 16'hFFFF) s.count = s.count + 16'd1;
      end
    end else if (s.pending) begin
      if (n == s.due) s = deliver(s);
    end else if (req) begin
      if (ws == 0) s = deliver(s);
      else begin s.pending = 1'b1; s.due = n + ws; end
    end
    return s;
  endfunction

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("d%0d_mem_addr", k), 64'(mem_addr[k]), 64'(m[k].pc));
      check_eq($sformatf("d%0d_ir", k), 64'(ir[k]), 64'(m[k].ir));
      check_eq($sformatf("d%0d_ir_valid", k), 64'(ir_valid[k]), 64'(m[k].valid));
      check_eq($sformatf("d%0d_pc_out", k), 64'(pc_out[k]), 64'(m[k].pc_out));
      check_eq($sformatf("d%0d_align_err", k), 64'(align_err[k]), 64'(m[k].align));
      check_eq($sformatf("d%0d_fetch_count", k), 64'(fetch_count[k]), 64'(m[k].count));
    end
  endtask

  // One clock: drive at negedge, step the model at posedge, compare at the next negedge.
  task automatic cycle(bit req, bit rdy, bit redir, logic [23:0] ra);
    fetch_req = req; ir_ready = rdy; redirect_en = redir; redirect_addr = ra;
    @(posedge clk);
    edge_n++;
    for (int k = 0; k < 2; k++) m[k] = model_step(m[k], WS[k], edge_n, req, rdy, redir, ra);
    @(negedge clk);
    check_all();
  endtask

  // Assert reset mid-low-phase (no clock edge involved) and release at the next negedge.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    fetch_req = 1'b0; ir_ready = 1'b0; redirect_en = 1'b0; redirect_addr = '0;
    #1;
    for (int k = 0; k < 2; k++) m[k] = model_reset(k);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
  endtask

  initial begin
    n_checks = 0; n_pass = 0; edge_n = 0;
    rst_n = 1'b0; fetch_req = 1'b0; ir_ready = 1'b0; redirect_en = 1'b0; redirect_addr = '0;
    for (int k = 0; k < 2; k++) m[k] = model_reset(k);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_all();
    check_eq("rst_mem_addr_wrap_inst", 64'(mem_addr[1]), 64'h0000_0000_00FF_FFFC);

    // Zero-wait fetch of word 0; 3-wait instance must not go valid early.
    cycle(1'b1, 1'b0, 1'b0, '0);
    check_eq("ws0_ir", 64'(ir[0]), 64'h0000_0000_F411_3005);
    check_eq("ws0_valid", 64'(ir_valid[0]), 64'd1);
    check_eq("ws0_pc_out", 64'(pc_out[0]), 64'd0);
    cycle(1'b0, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b0, '0);
    check_eq("ws3_no_early", 64'(ir_valid[1]), 64'd0);
    cycle(1'b0, 1'b1, 1'b0, '0);
    check_eq("ws0_next_addr", 64'(mem_addr[0]), 64'd4);
    check_eq("ws0_count", 64'(fetch_count[0]), 64'd1);
    check_eq("ws3_latency", 64'(ir_valid[1]), 64'd1);
    check_eq("ws3_pc_out", 64'(pc_out[1]), 64'h00FF_FFFC);
    cycle(1'b0, 1'b1, 1'b0, '0);
    check_eq("pc_wrap", 64'(mem_addr[1]), 64'd0);
    check_eq("ws3_drop_valid", 64'(ir_valid[1]), 64'd0);

    // Second fetch, then redirect to 0x10 in the 2nd WAIT cycle.
    cycle(1'b1, 1'b0, 1'b0, '0);
    check_eq("ws0_word4", 64'(ir[0]), 64'h0000_0000_F413_1007);
    check_eq("ws0_pc_out4", 64'(pc_out[0]), 64'd4);
    cycle(1'b0, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b1, 24'h000010);
    check_eq("redir_addr", 64'(mem_addr[1]), 64'h10);
    check_eq("redir_no_valid", 64'(ir_valid[1]), 64'd0);
    check_eq("redir_count", 64'(fetch_count[1]), 64'd1);
    check_eq("redir_drop_count", 64'(fetch_count[0]), 64'd1);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, '0);
    check_eq("redir_no_late_valid", 64'(ir_valid[1]), 64'd0);
    cycle(1'b1, 1'b0, 1'b0, '0);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, '0);
    check_eq("redir_word", 64'(ir[1]), 64'(mem_word(24'h000010)));
    check_eq("redir_pc_out", 64'(pc_out[1]), 64'h10);

    // Misaligned redirect in VALID with ir_ready high: dropped, not counted.
    cycle(1'b0, 1'b1, 1'b1, 24'h000015);
    check_eq("mis_pc", 64'(mem_addr[1]), 64'h14);
    check_eq("mis_align", 64'(align_err[1]), 64'd1);
    check_eq("mis_count", 64'(fetch_count[1]), 64'd1);
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b0, '0);
    check_eq("align_sticky", 64'(align_err[1]), 64'd1);

    // Reset asserted mid-WAIT.
    async_reset();
    check_eq("ar_valid", 64'(ir_valid[1]), 64'd0);
    check_eq("ar_ir", 64'(ir[1]), 64'd0);
    check_eq("ar_addr", 64'(mem_addr[1]), 64'h00FF_FFFC);
    check_eq("ar_align", 64'(align_err[1]), 64'd0);
    cycle(1'b1, 1'b0, 1'b0, '0);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, '0);
    check_eq("ar_refetch", 64'(ir[1]), 64'(mem_word(24'hFFFFFC)));
    check_eq("ar_refetch_valid", 64'(ir_valid[1]), 64'd1);

    // Random traffic with occasional redirects and resets.
    for (int i = 0; i < 4000; i++) begin
      logic [23:0] ra;
      bit          rd;
      ra = 24'($urandom());
      if ($urandom_range(0, 2) == 0) ra = 24'hFFFFF0 | 24'($urandom_range(0, 15));
      rd = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 299) == 0) async_reset();
      cycle(($urandom_range(0, 9) < 6), ($urandom_range(0, 1) == 1), rd, ra);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ifetch_ctrl.md
# ifetch_ctrl

Instruction-fetch sequencer for the multicycle processor. Owns the program counter, drives the address of the 32-bit instruction memory, waits a configurable number of memory wait states, and latches the returned word into the instruction register. It presents that word to the control unit under a valid/ready handshake, and supports PC redirection for branches and jumps.

## Interface
- ADDR_WIDTH, 24, instruction-memory byte-address width; also the PC width.
- RESET_PC, 0, PC value after reset; must be word-aligned.
- WAIT_STATES, 0, extra cycles the memory needs before mem_rdata is valid (0..15).
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_addr  out  ADDR_WIDTH  byte address to instruction memory; always equals pc.
- mem_rdata  in  32  instruction word returned by memory.
- fetch_req  in  1  control unit requests the next instruction; sampled in IDLE only.
- ir  out  32  latched instruction.
- ir_valid  out  1  ir holds an unconsumed instruction.
- ir_ready  in  1  control unit consumes ir; a transfer occurs when ir_valid && ir_ready.
- pc_out  out  ADDR_WIDTH  address of the instruction in ir.
- redirect_en  in  1  load a new PC (branch or jump).
- redirect_addr  in  ADDR_WIDTH  redirect target.
- align_err  out  1  sticky flag: a redirect target had non-zero bits [1:0].
- fetch_count  out  16  count of completed transfers; saturates at 16'hFFFF.

## Operation
- Reset values:
  - FSM = IDLE, pc = RESET_PC, ir = 0, pc_out = RESET_PC.
  - ir_valid = 0, align_err = 0, fetch_count = 0.
- FSM states are IDLE, WAIT and VALID.
- IDLE:
  - On fetch_req with WAIT_STATES == 0: ir <= mem_rdata, pc_out <= pc, go to VALID.
  - On fetch_req with WAIT_STATES > 0: wait counter <= WAIT_STATES-1, go to WAIT.
- WAIT:
  - While the counter is non-zero, decrement it.
  - When the counter is 0: ir <= mem_rdata, pc_out <= pc, go to VALID.
  - fetch_req is ignored.
- VALID:
  - ir_valid = 1; ir and pc_out hold steady.
  - On ir_ready: pc <= pc + 4, fetch_count++ (saturating), go to IDLE.
  - fetch_req is ignored.
- Redirect (any state; highest priority):
  - pc <= {redirect_addr[ADDR_WIDTH-1:2], 2'b00}; go to IDLE.
  - Aborts an in-flight WAIT and drops a VALID instruction; that dropped instruction is not counted, even if ir_ready is high in the same cycle.
  - If redirect_addr[1:0] != 0, align_err <= 1. It stays set until reset.
- fetch_req together with redirect_en in IDLE: the redirect wins and the request is dropped. The control unit must reissue it.
- PC arithmetic is modulo 2^ADDR_WIDTH: pc = all-ones-minus-3 + 4 wraps to 0.
- ir keeps its last value outside VALID (it is not cleared).

## Timing
- mem_addr is registered (equals pc) and stable through IDLE and WAIT.
- Fetch latency: fetch_req high in IDLE at cycle T gives ir_valid high in cycle T+1+WAIT_STATES.
- ir_valid is a registered output and falls in the cycle after the accepting ir_ready edge.
- Minimum fetch-to-fetch interval is 2+WAIT_STATES cycles, with fetch_req high in the IDLE cycle.
- Asserting rst_n low mid-WAIT or mid-VALID returns all outputs to their reset values immediately (asynchronously). Fetching restarts at RESET_PC.

## Structure
- Shared package ifetch_pkg holds:
  - the state enum (IDLE, WAIT, VALID);
  - INST_BYTES = 4;
  - the 32-bit instruction word typedef.
- One sub-module, fetch_wait_cnt: a 4-bit down-counter with load, decrement and a zero flag, instantiated once.

## Test plan
- Reset release, WAIT_STATES=0, memory word 0 = 0xF4113005, fetch_req for 1 cycle -> next cycle ir_valid=1, ir=0xF4113005, pc_out=0. ir_ready -> mem_addr=4, fetch_count=1.
- WAIT_STATES=3, word 4 = 0xF4131007, second fetch -> ir_valid rises exactly 4 cycles after fetch_req with ir=0xF4131007, pc_out=4. No early valid.
- WAIT_STATES=3, redirect_en with redirect_addr=0x10 in the 2nd WAIT cycle -> IDLE, mem_addr=0x10, no ir_valid. The next fetch returns word 0x10. fetch_count is unchanged.
- redirect_en with redirect_addr=0x15 in VALID while ir_ready=1 -> pc=0x14, align_err=1 and stays 1 through later fetches, fetch_count is not incremented.
- RESET_PC=0xFFFFFC (ADDR_WIDTH=24), one fetch and consume -> mem_addr wraps to 0x000000.
- Assert rst_n low mid-WAIT -> ir_valid=0, ir=0, mem_addr=RESET_PC immediately. After release, fetch_req returns the RESET_PC word.
